// File: rtl/regex_nfa_engine.sv
// Chain NFA matcher for one PCRE-style payload rule: one state per class line, optional
// self-loops, sticky match with first-match offset, anchor mode and a depth window.
module regex_nfa_engine #(
    parameter int unsigned                     NUM_CLASSES = 32,
    parameter int unsigned                     NUM_STATES  = 8,
    parameter int unsigned                     SEL_W       = 5,
    parameter logic [NUM_STATES*SEL_W-1:0]     CLASS_SEL   = '0,
    parameter logic [NUM_STATES-1:0]           LOOP_MASK   = '0,
    parameter bit                              ANCHORED    = 1'b1,
    parameter int unsigned                     DEPTH       = 0,
    parameter int unsigned                     OFFSET_W    = 16
) (
    input  logic                   clk,
    input  logic                   sod,
    input  logic                   en,
    input  logic [NUM_CLASSES-1:0] in_class,
    output logic                   match,
    output logic                   match_pulse,
    output logic [OFFSET_W-1:0]    match_offset,
    output logic                   active,
    output logic [OFFSET_W-1:0]    byte_cnt
);

    logic [NUM_STATES-1:0] st;
    logic [NUM_STATES-1:0] st_d;
    logic [NUM_STATES-1:0] cls;
    logic [NUM_STATES-1:0] pred;
    logic                  start;
    logic                  depth_ok;
    logic                  insp;
    logic                  hit;
    logic                  cnt_sat;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cls = '0;
        for (int i = 0; i < int'(NUM_STATES); i++) begin
            cls[i] = in_class[CLASS_SEL[i*SEL_W +: SEL_W]];
        end
    end

    always_comb begin
        depth_ok = 1'b1;
        if (DEPTH != 0) begin
            depth_ok = (32'(byte_cnt) < DEPTH);
        end
    end

    assign start   = ANCHORED ? (byte_cnt == '0) : 1'b1;
    assign insp    = en & ~sod & depth_ok;
    assign cnt_sat = &byte_cnt;

    // State i is fed by state i-1; state 0 is fed by the start token.
    generate
        if (NUM_STATES == 1) begin : g_pred_single
            assign pred = start;
        end else begin : g_pred_chain
            assign pred = {st[NUM_STATES-2:0], start};
        end
    endgenerate

    assign st_d   = cls & (pred | (LOOP_MASK & st));
    assign hit    = insp & st_d[NUM_STATES-1];
    assign active = |st;

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (sod) begin
            st           <= '0;
            match        <= 1'b0;
            match_pulse  <= 1'b0;
            match_offset <= '0;
            byte_cnt     <= '0;
        end else begin
            match_pulse <= 1'b0;
            if (en) begin
                // Bytes outside the depth window kill every partial chain.
                st <= insp ? st_d : '0;
                if (!cnt_sat) begin
                    byte_cnt <= byte_cnt + OFFSET_W'(1);
                end
                if (hit && !match) begin
                    match        <= 1'b1;
                    match_pulse  <= 1'b1;
                    match_offset <= byte_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_regex_nfa_engine.sv
// Bench for regex_nfa_engine: four instances of the "ab+c" chain (anchored, unanchored,
// depth-limited, 3-bit counter) share stimulus; a string-level model feeds a scoreboard.
module tb_regex_nfa_engine;

    localparam logic [14:0] SEL = {5'd2, 5'd1, 5'd0};
    localparam int NI = 4;

    typedef struct packed {
        logic [NI-1:0]       m;
        logic [NI-1:0]       p;
        logic [NI-1:0]       act;
        logic [NI-1:0][15:0] off;
        logic [NI-1:0][15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        sod = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] in_class = '0;

    logic        dm   [NI];
    logic        dp   [NI];
    logic        da   [NI];
    logic [15:0] doff [NI];
    logic [15:0] dcnt [NI];
    logic [2:0]  off_d;
    logic [2:0]  cnt_d;

    int errors = 0;
    int checks = 0;

    // Model configuration per instance: anchored, depth, counter ceiling.
    int anch_c [NI] = '{1, 0, 0, 0};
    int dep_c  [NI] = '{0, 0, 4, 0};
    int max_c  [NI] = '{65535, 65535, 65535, 7};

    byte  hist [$];
    bit   m_match [NI];
    int   m_off   [NI];
    bit   m_act   [NI];
    exp_t sb [$];
    exp_t mx;

    always #5 clk = ~clk;

    regex_nfa_engine #(.NUM_CLASSES(32), .NUM_STATES(3), .SEL_W(5), .CLASS_SEL(SEL),
                       .LOOP_MASK(3'b010), .ANCHORED(1'b1), .DEPTH(0), .OFFSET_W(16)) u_a (
        .clk(clk), .sod(sod), .en(en), .in_class(in_class), .match(dm[0]), .match_pulse(dp[0]),
        .match_offset(doff[0]), .active(da[0]), .byte_cnt(dcnt[0]));

    regex_nfa_engine #(.NUM_CLASSES(32), .NUM_STATES(3), .SEL_W(5), .CLASS_SEL(SEL),
                       .LOOP_MASK(3'b010), .ANCHORED(1'b0), .DEPTH(0), .OFFSET_W(16)) u_b (
        .clk(clk), .sod(sod), .en(en), .in_class(in_class), .match(dm[1]), .match_pulse(dp[1]),
        .match_offset(doff[1]), .active(da[1]), .byte_cnt(dcnt[1]));

    regex_nfa_engine #(.NUM_CLASSES(32), .NUM_STATES(3), .SEL_W(5), .CLASS_SEL(SEL),
                       .LOOP_MASK(3'b010), .ANCHORED(1'b0), .DEPTH(4), .OFFSET_W(16)) u_c (
        .clk(clk), .sod(sod), .en(en), .in_class(in_class), .match(dm[2]), .match_pulse(dp[2]),
        .match_offset(doff[2]), .active(da[2]), .byte_cnt(dcnt[2]));

    regex_nfa_engine #(.NUM_CLASSES(32), .NUM_STATES(3), .SEL_W(5), .CLASS_SEL(SEL),
                       .LOOP_MASK(3'b010), .ANCHORED(1'b0), .DEPTH(0), .OFFSET_W(3)) u_d (
        .clk(clk), .sod(sod), .en(en), .in_class(in_class), .match(dm[3]), .match_pulse(dp[3]),
        .match_offset(off_d), .active(da[3]), .byte_cnt(cnt_d));

    assign doff[3] = {13'b0, off_d};
    assign dcnt[3] = {13'b0, cnt_d};

    function automatic logic [31:0] cls_of(input byte c);
        case (c)
            "a":     return 32'h1;
            "b":     return 32'h2;
            "c":     return 32'h4;
            default: return 32'h20;
        endcase
    endfunction

    function automatic bit in_win(input int i, input int k);
        return (dep_c[i] == 0) || (k < dep_c[i]);
    endfunction

    // True when hist[k] ends a run "a b..b" (at least one b) that began on a legal start byte.
    function automatic bit b_run(input int i, input int k);
        int m;
        if (k < 0 || hist[k] != "b") return 1'b0;
        m = k;
        while (m >= 0 && hist[m] == "b") m--;
        return (m >= 0) && (hist[m] == "a") && (anch_c[i] == 0 || m == 0);
    endfunction

    function automatic bit hit_at(input int i, input int k);
        return in_win(i, k) && (hist[k] == "c") && b_run(i, k - 1);
    endfunction

    function automatic bit active_at(input int i, input int k);
        return in_win(i, k) && ((hist[k] == "a" && (anch_c[i] == 0 || k == 0)) ||
                                b_run(i, k) || hit_at(i, k));
    endfunction

    task automatic drive(input bit s, input bit e, input byte c);
        exp_t x;
        int   k;
        bit   h;
        x = '0;
        sod = s;
        en  = e;
        in_class = e ? cls_of(c) : $urandom();
        if (s) begin
            hist.delete();
            for (int i = 0; i < NI; i++) begin
                m_match[i] = 1'b0;
                m_off[i]   = 0;
                m_act[i]   = 1'b0;
            end
        end else if (e) begin
            k = hist.size();
            hist.push_back(c);
            for (int i = 0; i < NI; i++) begin
                h = hit_at(i, k);
                if (h && !m_match[i]) begin
                    x.p[i]   = 1'b1;
                    m_off[i] = (k > max_c[i]) ? max_c[i] : k;
                end
                m_match[i] = m_match[i] | h;
                m_act[i]   = active_at(i, k);
            end
        end
        for (int i = 0; i < NI; i++) begin
            x.m[i]   = m_match[i];
            x.act[i] = m_act[i];
            x.off[i] = 16'(m_off[i]);
            x.cnt[i] = 16'((hist.size() > max_c[i]) ? max_c[i] : hist.size());
        end
        sb.push_back(x);
        @(posedge clk);
        #3;
    endtask

    task automatic send_str(input string s);
        for (int j = 0; j < s.len(); j++) drive(1'b0, 1'b1, s[j]);
    endtask

    // Scoreboard: compare every instance one step after each driven edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mx = sb.pop_front();
            for (int i = 0; i < NI; i++) begin
                checks += 5;
                if (dm[i] !== mx.m[i]) begin
                    errors++;
                    $display("FAIL sb_match[%0d] t=%0t got=%b exp=%b", i, $time, dm[i], mx.m[i]);
                end
                if (dp[i] !== mx.p[i]) begin
                    errors++;
                    $display("FAIL sb_pulse[%0d] t=%0t got=%b exp=%b", i, $time, dp[i], mx.p[i]);
                end
                if (da[i] !== mx.act[i]) begin
                    errors++;
                    $display("FAIL sb_active[%0d] t=%0t got=%b exp=%b", i, $time, da[i], mx.act[i]);
                end
                if (doff[i] !== mx.off[i]) begin
                    errors++;
                    $display("FAIL sb_offset[%0d] t=%0t got=%0d exp=%0d", i, $time, doff[i], mx.off[i]);
                end
                if (dcnt[i] !== mx.cnt[i]) begin
                    errors++;
                    $display("FAIL sb_byte_cnt[%0d] t=%0t got=%0d exp=%0d", i, $time, dcnt[i], mx.cnt[i]);
                end
            end
        end
    end

    task automatic test_reset();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, "a");
        checks++;
        if ({dm[0], dp[0], da[0]} !== 3'b000 || dcnt[0] !== 16'd0 || doff[0] !== 16'd0) begin
            errors++;
            $display("FAIL reset got m=%b p=%b a=%b cnt=%0d off=%0d exp all 0",
                     dm[0], dp[0], da[0], dcnt[0], doff[0]);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 8'h00);
        send_str("abbbc");
        checks++;
        if (dm[0] !== 1'b1 || dp[0] !== 1'b1 || doff[0] !== 16'd4 || dcnt[0] !== 16'd5) begin
            errors++;
            $display("FAIL basic got m=%b p=%b off=%0d cnt=%0d exp m=1 p=1 off=4 cnt=5",
                     dm[0], dp[0], doff[0], dcnt[0]);
        end
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (dm[0] !== 1'b1 || dp[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_sticky got m=%b p=%b exp m=1 p=0", dm[0], dp[0]);
        end
    endtask

    task automatic test_anchor();
        drive(1'b1, 1'b0, 8'h00);
        send_str("xabc");
        checks++;
        if (dm[0] !== 1'b0) begin
            errors++;
            $display("FAIL anchor_late got=%b exp=0", dm[0]);
        end
        drive(1'b1, 1'b0, 8'h00);
        send_str("ac");
        checks++;
        if (dm[0] !== 1'b0) begin
            errors++;
            $display("FAIL anchor_no_b got=%b exp=0", dm[0]);
        end
        drive(1'b1, 1'b0, 8'h00);
        send_str("abc");
        checks++;
        if (dm[0] !== 1'b1 || doff[0] !== 16'd2) begin
            errors++;
            $display("FAIL anchor_abc got m=%b off=%0d exp m=1 off=2", dm[0], doff[0]);
        end
    endtask

    task automatic test_overlap();
        string s;
        int    pulses;
        s = "zzabcabc";
        pulses = 0;
        drive(1'b1, 1'b0, 8'h00);
        for (int j = 0; j < s.len(); j++) begin
            drive(1'b0, 1'b1, s[j]);
            if (dp[1] === 1'b1) pulses++;
        end
        checks++;
        if (dm[1] !== 1'b1 || doff[1] !== 16'd4 || pulses != 1) begin
            errors++;
            $display("FAIL overlap got m=%b off=%0d pulses=%0d exp m=1 off=4 pulses=1",
                     dm[1], doff[1], pulses);
        end
    endtask

    task automatic test_depth();
        drive(1'b1, 1'b0, 8'h00);
        send_str("zzabc");
        checks++;
        if (dm[2] !== 1'b0) begin
            errors++;
            $display("FAIL depth_out got=%b exp=0", dm[2]);
        end
        drive(1'b1, 1'b0, 8'h00);
        send_str("zabc");
        checks++;
        if (dm[2] !== 1'b1 || doff[2] !== 16'd3) begin
            errors++;
            $display("FAIL depth_in got m=%b off=%0d exp m=1 off=3", dm[2], doff[2]);
        end
    endtask

    task automatic test_en_gaps();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, "a");
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, "b");
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, "c");
        checks++;
        if (dm[0] !== 1'b1 || doff[0] !== 16'd2 || dcnt[0] !== 16'd3) begin
            errors++;
            $display("FAIL gaps got m=%b off=%0d cnt=%0d exp m=1 off=2 cnt=3",
                     dm[0], doff[0], dcnt[0]);
        end
        drive(1'b1, 1'b1, "a");
        checks++;
        if (dm[0] !== 1'b0 || dp[0] !== 1'b0 || da[0] !== 1'b0 || dcnt[0] !== 16'd0) begin
            errors++;
            $display("FAIL sod_with_en got m=%b p=%b a=%b cnt=%0d exp all 0",
                     dm[0], dp[0], da[0], dcnt[0]);
        end
        send_str("abc");
        checks++;
        if (dm[0] !== 1'b1 || doff[0] !== 16'd2) begin
            errors++;
            $display("FAIL after_sod got m=%b off=%0d exp m=1 off=2", dm[0], doff[0]);
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b0, 8'h00);
        send_str("zzzzzzzabc");
        checks++;
        if (dm[3] !== 1'b1 || dcnt[3] !== 16'd7 || doff[3] !== 16'd7) begin
            errors++;
            $display("FAIL saturation got m=%b cnt=%0d off=%0d exp m=1 cnt=7 off=7",
                     dm[3], dcnt[3], doff[3]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_basic();
        test_anchor();
        test_overlap();
        test_depth();
        test_en_gaps();
        test_saturation();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
